rx_frame_sequencer: RTL and testbench

Frame-level controller for the 802.11a serial receive chain. It detects the preamble run, steers the SIGNAL-field coded bits into the Viterbi decoder, and checks the decoded SIGNAL word. It then computes the DATA-field geometry (Nsym, pad bits, coded-bit budget) and gates the DATA coded bits to the deinterleaver/decoder/descrambler path. It sits between the coded-bit source and the Decoder_Viterbi / DeInterleaver / DeScrambler instances, replacing their ad-hoc counter-based sequencing.

---
 rtl/rx_frame_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_rx_frame_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sequencer.sv
// Frame-level sequencer for the 802.11a serial receive chain: preamble-run
// detection, SIGNAL-field steering and checking, DATA geometry calculation
// and gating of DATA coded bits toward the deinterleaver/decoder path.
//
// state | meaning
// ------+---------------------------------------------------------------
// HUNT  | counting consecutive accepted '1' coded bits for frame sync
// SIG   | forwarding SIGNAL coded bits, collecting decoded SIGNAL bits
// CHECK | one cycle: validate the SIGNAL word, latch RATE/LENGTH
// CALC  | repeated subtraction of Ndbps to derive Num_Sym/Num_Pads/budget
// DATA  | forwarding DATA coded bits until the coded budget is used up
// DRAIN | waiting for the output stage to deliver the last DATA bit
module rx_frame_sequencer #(
   parameter int SYNC_LEN  = 12,
   parameter int SIG_CODED = 48,
   parameter int MAX_LEN   = 4095
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        In_Valid,
   input  logic        x,
   output logic        In_Ready,
   input  logic        Dec_Valid,
   input  logic        Dec_Bit,
   input  logic        Data_Done,
   output logic        Sig_Start,
   output logic        Sig_En,
   output logic        Data_Start,
   output logic        Data_En,
   output logic [3:0]  Rate,
   output logic [11:0] Length,
   output logic [8:0]  Ncbps,
   output logic [7:0]  Ndbps,
   output logic [10:0] Num_Sym,
   output logic [7:0]  Num_Pads,
   output logic        Busy,
   output logic        Frame_Err,
   output logic        Frame_Done
);

   localparam int RUN_W = $clog2(SYNC_LEN + 1);
   localparam int CNT_W = $clog2(SIG_CODED + 1);

   typedef enum logic [2:0] {HUNT, SIG, CHECK, CALC, DATA, DRAIN} state_t;

   state_t       state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] coded_q, coded_d;
   logic [4:0]   dec_q, dec_d;
   logic [23:0]  sig_word_q, sig_word_d;
   logic [3:0]   rate_q, rate_d;
   logic [11:0]  length_q, length_d;
   logic [8:0]   ncbps_q, ncbps_d;
   logic [7:0]   ndbps_q, ndbps_d;
   logic [10:0]  num_sym_q, num_sym_d;
   logic [7:0]   num_pads_q, num_pads_d;
   logic [15:0]  rem_q, rem_d;
   logic [19:0]  budget_q, budget_d;
   logic         sig_start_q, sig_start_d;
   logic         data_start_q, data_start_d;
   logic         frame_err_q, frame_err_d;
   logic         frame_done_q, frame_done_d;

   logic         ready_raw;
   logic         xfer;
   logic [3:0]   sig_rate;
   logic [11:0]  sig_length;
   logic         rate_ok;
   logic [8:0]   tab_ncbps;
   logic [7:0]   tab_ndbps;
   logic         sig_ok;

   // R1 is transmitted first and lands in sig_word bit 0, but is reported as Rate[3]
   assign sig_rate   = {sig_word_q[0], sig_word_q[1], sig_word_q[2], sig_word_q[3]};
   assign sig_length = sig_word_q[16:5];

   // rate table lookup for the collected SIGNAL word
   always_comb begin
      rate_ok   = 1'b1;
      tab_ncbps = 9'd0;
      tab_ndbps = 8'd0;
      case (sig_rate)
         4'b1101: begin tab_ncbps = 9'd48;  tab_ndbps = 8'd24;  end
         4'b1111: begin tab_ncbps = 9'd48;  tab_ndbps = 8'd36;  end
         4'b0101: begin tab_ncbps = 9'd96;  tab_ndbps = 8'd48;  end
         4'b0111: begin tab_ncbps = 9'd96;  tab_ndbps = 8'd72;  end
         4'b1001: begin tab_ncbps = 9'd192; tab_ndbps = 8'd96;  end
         4'b1011: begin tab_ncbps = 9'd192; tab_ndbps = 8'd144; end
         4'b0001: begin tab_ncbps = 9'd288; tab_ndbps = 8'd192; end
         4'b0011: begin tab_ncbps = 9'd288; tab_ndbps = 8'd216; end
         default: rate_ok = 1'b0;
      endcase
   end

   assign sig_ok = rate_ok && !sig_word_q[4] && !(^sig_word_q[17:0]) &&
                   (sig_word_q[23:18] == 6'd0) && (sig_length != 12'd0) &&
                   (int'(sig_length) <= MAX_LEN);

   // input handshake; held low while reset is asserted
   always_comb begin
      ready_raw = 1'b0;
      case (state_q)
         HUNT:    ready_raw = 1'b1;
         SIG:     ready_raw = (coded_q != CNT_W'(SIG_CODED));
         DATA:    ready_raw = 1'b1;
         default: ready_raw = 1'b0;
      endcase
   end

   assign In_Ready = ready_raw & Reset;
   assign xfer     = In_Valid & In_Ready;
   assign Sig_En   = xfer & (state_q == SIG);
   assign Data_En  = xfer & (state_q == DATA);

   // next-state and datapath updates
   always_comb begin
      state_d      = state_q;
      run_d        = run_q;
      coded_d      = coded_q;
      dec_d        = dec_q;
      sig_word_d   = sig_word_q;
      rate_d       = rate_q;
      length_d     = length_q;
      ncbps_d      = ncbps_q;
      ndbps_d      = ndbps_q;
      num_sym_d    = num_sym_q;
      num_pads_d   = num_pads_q;
      rem_d        = rem_q;
      budget_d     = budget_q;
      sig_start_d  = 1'b0;
      data_start_d = 1'b0;
      frame_err_d  = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         HUNT: begin
            if (xfer) begin
               if (x) begin
                  if (run_q == RUN_W'(SYNC_LEN - 1)) begin
                     state_d     = SIG;
                     run_d       = '0;
                     coded_d     = '0;
                     dec_d       = 5'd0;
                     sig_start_d = 1'b1;
                  end else begin
                     run_d = run_q + 1'b1;
                  end
               end else begin
                  run_d = '0;
               end
            end
         end
         SIG: begin
            if (xfer) coded_d = coded_q + 1'b1;
            // the decoder cannot have output before it has been started
            if (Dec_Valid && !sig_start_q) begin
               sig_word_d = {Dec_Bit, sig_word_q[23:1]};
               dec_d      = dec_q + 5'd1;
               if (dec_q == 5'd23) state_d = CHECK;
            end
         end
         CHECK: begin
            rate_d   = sig_rate;
            length_d = sig_length;
            if (sig_ok) begin
               ncbps_d    = tab_ncbps;
               ndbps_d    = tab_ndbps;
               num_sym_d  = 11'd0;
               num_pads_d = 8'd0;
               rem_d      = 16'd22 + {1'b0, sig_length, 3'b000};
               budget_d   = 20'd0;
               state_d    = CALC;
            end else begin
               frame_err_d = 1'b1;
               run_d       = '0;
               state_d     = HUNT;
            end
         end
         CALC: begin
            num_sym_d = num_sym_q + 11'd1;
            budget_d  = budget_q + 20'(ncbps_q);
            if (rem_q > 16'(ndbps_q)) begin
               rem_d = rem_q - 16'(ndbps_q);
            end else begin
               // rem_q <= Ndbps here, so it fits in 8 bits
               num_pads_d   = ndbps_q - rem_q[7:0];
               data_start_d = 1'b1;
               state_d      = DATA;
            end
         end
         DATA: begin
            if (xfer) begin
               budget_d = budget_q - 20'd1;
               if (budget_q == 20'd1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (Data_Done) begin
               frame_done_d = 1'b1;
               state_d      = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= HUNT;
         run_q        <= '0;
         coded_q      <= '0;
         dec_q        <= 5'd0;
         sig_word_q   <= 24'd0;
         rate_q       <= 4'd0;
         length_q     <= 12'd0;
         ncbps_q      <= 9'd0;
         ndbps_q      <= 8'd0;
         num_sym_q    <= 11'd0;
         num_pads_q   <= 8'd0;
         rem_q        <= 16'd0;
         budget_q     <= 20'd0;
         sig_start_q  <= 1'b0;
         data_start_q <= 1'b0;
         frame_err_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         coded_q      <= coded_d;
         dec_q        <= dec_d;
         sig_word_q   <= sig_word_d;
         rate_q       <= rate_d;
         length_q     <= length_d;
         ncbps_q      <= ncbps_d;
         ndbps_q      <= ndbps_d;
         num_sym_q    <= num_sym_d;
         num_pads_q   <= num_pads_d;
         rem_q        <= rem_d;
         budget_q     <= budget_d;
         sig_start_q  <= sig_start_d;
         data_start_q <= data_start_d;
         frame_err_q  <= frame_err_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign Sig_Start  = sig_start_q;
   assign Data_Start = data_start_q;
   assign Frame_Err  = frame_err_q;
   assign Frame_Done = frame_done_q;
   assign Rate       = rate_q;
   assign Length     = length_q;
   assign Ncbps      = ncbps_q;
   assign Ndbps      = ndbps_q;
   assign Num_Sym    = num_sym_q;
   assign Num_Pads   = num_pads_q;
   assign Busy       = (state_q != HUNT);

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Self-checking bench for rx_frame_sequencer: a table of SIGNAL words with
// hand-computed geometry, plus sync, reset-abort and boundary sequences.
module tb_rx_frame_sequencer;

   localparam int SYNC_LEN = 12;

   logic        Clk, Reset, In_Valid, x, Dec_Valid, Dec_Bit, Data_Done;
   logic        In_Ready, Sig_Start, Sig_En, Data_Start, Data_En;
   logic [3:0]  Rate;
   logic [11:0] Length;
   logic [8:0]  Ncbps;
   logic [7:0]  Ndbps;
   logic [10:0] Num_Sym;
   logic [7:0]  Num_Pads;
   logic        Busy, Frame_Err, Frame_Done;

   rx_frame_sequencer dut (
      .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .x(x), .In_Ready(In_Ready),
      .Dec_Valid(Dec_Valid), .Dec_Bit(Dec_Bit), .Data_Done(Data_Done),
      .Sig_Start(Sig_Start), .Sig_En(Sig_En), .Data_Start(Data_Start), .Data_En(Data_En),
      .Rate(Rate), .Length(Length), .Ncbps(Ncbps), .Ndbps(Ndbps),
      .Num_Sym(Num_Sym), .Num_Pads(Num_Pads), .Busy(Busy),
      .Frame_Err(Frame_Err), .Frame_Done(Frame_Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0]  rate;
      logic [11:0] len;
      logic        res;
      logic        par_flip;
      logic [5:0]  tail;
      logic        ok;
      logic [8:0]  ncbps;
      logic [7:0]  ndbps;
      logic [10:0] nsym;
      logic [7:0]  npads;
   } vec_t;

   vec_t vecs [15];

   int n_checks = 0;
   int n_fail   = 0;
   int n_sig_start = 0, n_sig_en = 0, n_data_start = 0, n_data_en = 0;
   int n_frame_err = 0, n_frame_done = 0;

   // pulse/enable counters, sampled mid-cycle
   always @(negedge Clk) begin
      if (Sig_Start)  n_sig_start++;
      if (Sig_En)     n_sig_en++;
      if (Data_Start) n_data_start++;
      if (Data_En)    n_data_en++;
      if (Frame_Err)  n_frame_err++;
      if (Frame_Done) n_frame_done++;
   end

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   // call between a rising edge and the following falling edge
   task automatic send_bit(input logic b);
      int t;
      t = 0;
      In_Valid = 1'b1;
      x = b;
      forever begin
         @(negedge Clk);
         if (In_Ready) begin
            @(posedge Clk); #1;
            break;
         end
         t++;
         if (t >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout: In_Ready stayed %0d for %0d cycles, expected 1", In_Ready, t);
            $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
            $finish;
         end
      end
      In_Valid = 1'b0;
   endtask

   task automatic pulse_reset();
      Reset = 1'b0;
      In_Valid = 1'b0;
      Dec_Valid = 1'b0;
      Data_Done = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk); #1;
   endtask

   function automatic logic [23:0] make_sig(input logic [3:0] r, input logic [11:0] l,
                                            input logic res, input logic pf, input logic [5:0] t);
      logic [23:0] w;
      w = '0;
      w[0] = r[3]; w[1] = r[2]; w[2] = r[1]; w[3] = r[0];
      w[4] = res;
      w[16:5] = l;
      w[17] = (^w[16:0]) ^ pf;
      w[23:18] = t;
      return w;
   endfunction

   task automatic run_frame(input int idx, input vec_t v, input int abort_after);
      logic [23:0] w;
      int s0, se0, ds0, de0, fe0, fd0, k, budget;
      logic viol;
      w = make_sig(v.rate, v.len, v.res, v.par_flip, v.tail);
      s0 = n_sig_start; se0 = n_sig_en; ds0 = n_data_start;
      de0 = n_data_en; fe0 = n_frame_err; fd0 = n_frame_done;
      repeat (SYNC_LEN) send_bit(1'b1);
      repeat (48) send_bit(1'($urandom_range(0, 1)));
      @(negedge Clk);
      chk("sig_ready_drop", idx, In_Ready, 0);
      chk("sig_start_cnt", idx, n_sig_start - s0, 1);
      chk("sig_en_cnt", idx, n_sig_en - se0, 48);
      @(posedge Clk); #1;
      for (int i = 0; i < 24; i++) begin
         Dec_Valid = 1'b1;
         Dec_Bit = w[i];
         @(posedge Clk); #1;
      end
      Dec_Valid = 1'b0;
      Dec_Bit = 1'b0;
      if (v.ok) begin
         k = 0;
         viol = 1'b0;
         @(negedge Clk);
         while (!Data_Start && k < 2000) begin
            if (In_Ready) viol = 1'b1;
            k++;
            @(negedge Clk);
         end
         chk("start_latency", idx, k, 32'(v.nsym) + 1);
         chk("calc_ready_low", idx, viol, 0);
         chk("rate", idx, Rate, v.rate);
         chk("length", idx, Length, v.len);
         chk("ncbps", idx, Ncbps, v.ncbps);
         chk("ndbps", idx, Ndbps, v.ndbps);
         chk("num_sym", idx, Num_Sym, v.nsym);
         chk("num_pads", idx, Num_Pads, v.npads);
         budget = int'(v.nsym) * int'(v.ncbps);
         @(posedge Clk); #1;
         Data_Done = 1'b1;
         @(posedge Clk); #1;
         Data_Done = 1'b0;
         if (abort_after > 0) begin
            repeat (abort_after) send_bit(1'($urandom_range(0, 1)));
            return;
         end
         repeat (budget) send_bit(1'($urandom_range(0, 1)));
         @(negedge Clk);
         chk("drain_ready", idx, In_Ready, 0);
         chk("data_en_cnt", idx, n_data_en - de0, budget);
         chk("drain_busy", idx, Busy, 1);
         @(posedge Clk); #1;
         Data_Done = 1'b1;
         @(posedge Clk); #1;
         Data_Done = 1'b0;
         @(negedge Clk);
         chk("frame_done", idx, Frame_Done, 1);
         chk("idle_busy", idx, Busy, 0);
         @(negedge Clk);
         chk("frame_done_cnt", idx, n_frame_done - fd0, 1);
         chk("no_frame_err", idx, n_frame_err - fe0, 0);
         chk("data_start_cnt", idx, n_data_start - ds0, 1);
      end else begin
         repeat (4) @(negedge Clk);
         chk("frame_err_cnt", idx, n_frame_err - fe0, 1);
         chk("rej_no_data_start", idx, n_data_start - ds0, 0);
         chk("rej_busy", idx, Busy, 0);
         chk("rej_rate", idx, Rate, v.rate);
         chk("rej_length", idx, Length, v.len);
      end
      @(posedge Clk); #1;
   endtask

   initial begin
      int s0, fe0, fd0;
      //            rate     len      res   pflip tail  ok    ncbps   ndbps  nsym     npads
      vecs[0]  = '{4'b1101, 12'd100, 1'b0, 1'b0, 6'd0, 1'b1, 9'd48,  8'd24,  11'd35, 8'd18};
      vecs[1]  = '{4'b0011, 12'd26,  1'b0, 1'b0, 6'd0, 1'b1, 9'd288, 8'd216, 11'd2,  8'd202};
      vecs[2]  = '{4'b1101, 12'd5,   1'b0, 1'b0, 6'd0, 1'b1, 9'd48,  8'd24,  11'd3,  8'd10};
      vecs[3]  = '{4'b0101, 12'd13,  1'b0, 1'b0, 6'd0, 1'b1, 9'd96,  8'd48,  11'd3,  8'd18};
      vecs[4]  = '{4'b1001, 12'd50,  1'b0, 1'b0, 6'd0, 1'b1, 9'd192, 8'd96,  11'd5,  8'd58};
      vecs[5]  = '{4'b1011, 12'd1,   1'b0, 1'b0, 6'd0, 1'b1, 9'd192, 8'd144, 11'd1,  8'd114};
      vecs[6]  = '{4'b0111, 12'd9,   1'b0, 1'b0, 6'd0, 1'b1, 9'd96,  8'd72,  11'd2,  8'd50};
      vecs[7]  = '{4'b0001, 12'd40,  1'b0, 1'b0, 6'd0, 1'b1, 9'd288, 8'd192, 11'd2,  8'd42};
      vecs[8]  = '{4'b1111, 12'd7,   1'b0, 1'b0, 6'd0, 1'b1, 9'd48,  8'd36,  11'd3,  8'd30};
      vecs[9]  = '{4'b1101, 12'd100, 1'b0, 1'b1, 6'd0, 1'b0, 9'd0,   8'd0,   11'd0,  8'd0};
      vecs[10] = '{4'b1101, 12'd100, 1'b1, 1'b0, 6'd0, 1'b0, 9'd0,   8'd0,   11'd0,  8'd0};
      vecs[11] = '{4'b0000, 12'd100, 1'b0, 1'b0, 6'd0, 1'b0, 9'd0,   8'd0,   11'd0,  8'd0};
      vecs[12] = '{4'b1101, 12'd0,   1'b0, 1'b0, 6'd0, 1'b0, 9'd0,   8'd0,   11'd0,  8'd0};
      vecs[13] = '{4'b1101, 12'd100, 1'b0, 1'b0, 6'd4, 1'b0, 9'd0,   8'd0,   11'd0,  8'd0};
      vecs[14] = '{4'b1010, 12'd20,  1'b0, 1'b0, 6'd0, 1'b0, 9'd0,   8'd0,   11'd0,  8'd0};

      Reset = 1'b0;
      In_Valid = 1'b1;
      x = 1'b1;
      Dec_Valid = 1'b0;
      Dec_Bit = 1'b0;
      Data_Done = 1'b0;
      #12;
      chk("rst_in_ready", -1, In_Ready, 0);
      chk("rst_sig_en", -1, Sig_En, 0);
      chk("rst_busy", -1, Busy, 0);
      chk("rst_rate", -1, Rate, 0);
      chk("rst_num_sym", -1, Num_Sym, 0);
      chk("rst_sig_start", -1, Sig_Start, 0);
      In_Valid = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk); #1;

      // broken run: 11 ones, a zero, then a fresh run of 12
      s0 = n_sig_start;
      repeat (11) send_bit(1'b1);
      send_bit(1'b0);
      repeat (11) send_bit(1'b1);
      @(negedge Clk);
      chk("sync_early", -2, n_sig_start - s0, 0);
      chk("sync_early_busy", -2, Busy, 0);
      @(posedge Clk); #1;
      send_bit(1'b1);
      @(negedge Clk);
      chk("sync_start", -2, Sig_Start, 1);
      chk("sync_busy", -2, Busy, 1);
      @(posedge Clk); #1;
      pulse_reset();

      for (int i = 0; i < 15; i++) run_frame(i, vecs[i], 0);

      // asynchronous reset in the middle of DATA
      fe0 = n_frame_err;
      fd0 = n_frame_done;
      run_frame(99, vecs[0], 100);
      In_Valid = 1'b1;
      x = 1'b1;
      #2 Reset = 1'b0;
      #1;
      chk("abort_in_ready", 99, In_Ready, 0);
      chk("abort_data_en", 99, Data_En, 0);
      chk("abort_busy", 99, Busy, 0);
      chk("abort_num_sym", 99, Num_Sym, 0);
      chk("abort_rate", 99, Rate, 0);
      chk("abort_length", 99, Length, 0);
      chk("abort_ncbps", 99, Ncbps, 0);
      @(negedge Clk);
      Reset = 1'b1;
      In_Valid = 1'b0;
      @(posedge Clk); #1;
      chk("abort_no_err", 99, n_frame_err - fe0, 0);
      chk("abort_no_done", 99, n_frame_done - fd0, 0);
      s0 = n_sig_start;
      repeat (11) send_bit(1'b1);
      @(negedge Clk);
      chk("abort_resync_early", 99, n_sig_start - s0, 0);
      @(posedge Clk); #1;
      send_bit(1'b1);
      @(negedge Clk);
      chk("abort_resync", 99, Sig_Start, 1);
      @(posedge Clk); #1;
      pulse_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
